// File: rtl/sci_sched_pkg.sv
// Types, widths and the clock-divider helper shared by the periodic acquisition
// scheduler (sci_period_sched) and its timebase.
package sci_sched_pkg;

   localparam int INTERVAL_W = 16;
   localparam int SEQ_W      = 16;
   localparam int OVR_W      = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_REQ,
      ST_BUSY
   } sched_state_e;

   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/sched_timebase.sv
// Prescaler producing a one-cycle tick every DIV clocks; it is held at zero
// while disabled and restarts from zero on clr_i.
module sched_timebase #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i || !en_i || cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/sci_period_sched.sv
// Periodic acquisition scheduler: one req/ack/done transaction per INTERVAL ticks.
// Optional busy watchdog enabled by defining SCHED_WATCHDOG_EN.
module sci_period_sched
   import sci_sched_pkg::*;
#(
   parameter int          CLK_FREQ_HZ = 50000000,
   parameter int          TICK_HZ     = 1000,
   parameter logic [15:0] WDOG_TICKS  = 16'd1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable_i,
   input  logic [INTERVAL_W-1:0] interval_i,
   output logic                  trig_req,
   input  logic                  trig_ack,
   input  logic                  trig_done,
   output logic                  busy,
   output logic                  tick,
   output logic [SEQ_W-1:0]      seq_cnt,
   output logic [OVR_W-1:0]      overrun_cnt,
   output logic                  wdog_err
);

   localparam int DIV = calc_div(CLK_FREQ_HZ, TICK_HZ);

   sched_state_e          state_q, state_d;
   logic                  en_q, en_prev_q, en_rise;
   logic [INTERVAL_W-1:0] ivl_q, per_cnt_q, ivl_in;
   logic                  tb_en, tb_tick, expiry, wd_fire;
   logic                  trig_req_q, busy_q, wdog_err_q;
   logic [SEQ_W-1:0]      seq_q;
   logic [OVR_W-1:0]      ovr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q      <= 1'b0;
         en_prev_q <= 1'b0;
      end else begin
         en_q      <= enable_i;
         en_prev_q <= en_q;
      end
   end

   assign en_rise = en_q & ~en_prev_q;

   sched_timebase #(.DIV(DIV)) u_timebase (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (tb_en),
      .clr_i  (en_rise),
      .tick_o (tb_tick)
   );

   assign tick   = tb_tick & en_q;
   assign ivl_in = (interval_i == '0) ? INTERVAL_W'(1) : interval_i;
   assign expiry = tick && (per_cnt_q == ivl_q - INTERVAL_W'(1));

`ifdef SCHED_WATCHDOG_EN
   // Timebase keeps running in BUSY after disable so a hung readout still times out.
   logic [15:0] wd_cnt_q;

   assign tb_en   = en_q | (state_q == ST_BUSY);
   assign wd_fire = (state_q == ST_BUSY) && tb_tick && (wd_cnt_q == WDOG_TICKS - 16'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_q <= '0;
      end else if (state_q != ST_BUSY) begin
         wd_cnt_q <= '0;
      end else if (tb_tick) begin
         wd_cnt_q <= wd_cnt_q + 16'd1;
      end
   end
`else
   logic unused_wdog;

   assign tb_en       = en_q;
   assign wd_fire     = 1'b0;
   assign unused_wdog = ^WDOG_TICKS;
`endif

   // Interval is re-sampled only at period boundaries, so mid-period edits apply next period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ivl_q     <= '0;
         per_cnt_q <= '0;
      end else if (en_rise || expiry) begin
         ivl_q     <= ivl_in;
         per_cnt_q <= '0;
      end else if (tick) begin
         per_cnt_q <= per_cnt_q + INTERVAL_W'(1);
      end
   end

   // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: state_d = ST_IDLE;
         ST_WAIT: begin
            if (!en_q)       state_d = ST_IDLE;
            else if (expiry) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (trig_ack)   state_d = trig_done ? (en_q ? ST_WAIT : ST_IDLE) : ST_BUSY;
            else if (!en_q) state_d = ST_IDLE;
         end
         ST_BUSY: begin
            if (trig_done || wd_fire) state_d = en_q ? ST_WAIT : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (en_rise) state_d = ST_REQ;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         trig_req_q <= 1'b0;
         busy_q     <= 1'b0;
         seq_q      <= '0;
         ovr_q      <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         trig_req_q <= (state_d == ST_REQ);
         busy_q     <= (state_d == ST_REQ) || (state_d == ST_BUSY);
         if (en_rise) begin
            seq_q      <= '0;
            ovr_q      <= '0;
            wdog_err_q <= 1'b0;
         end else begin
            if (state_q == ST_REQ && trig_ack) seq_q <= seq_q + SEQ_W'(1);
            if (expiry && (state_q == ST_REQ || state_q == ST_BUSY) && ovr_q != '1)
               ovr_q <= ovr_q + OVR_W'(1);
            if (wd_fire) wdog_err_q <= 1'b1;
         end
      end
   end

   assign trig_req    = trig_req_q;
   assign busy        = busy_q;
   assign seq_cnt     = seq_q;
   assign overrun_cnt = ovr_q;
   assign wdog_err    = wdog_err_q;

endmodule

// File: tb/tb_sci_period_sched.sv
// Directed bench for sci_period_sched with DIV=10 (1 kHz clock, 100 Hz tick), WDOG_TICKS=4.
// Watchdog expectations follow SCHED_WATCHDOG_EN when it is defined.
module tb_sci_period_sched;

`ifdef SCHED_WATCHDOG_EN
   localparam logic EXP_WD_ERR = 1'b1;
   localparam logic EXP_WD_BUSY = 1'b0;
`else
   localparam logic EXP_WD_ERR = 1'b0;
   localparam logic EXP_WD_BUSY = 1'b1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable_i = 1'b0;
   logic [15:0] interval_i = 16'd0;
   logic        trig_ack = 1'b0;
   logic        trig_done = 1'b0;
   logic        trig_req, busy, tick, wdog_err;
   logic [15:0] seq_cnt;
   logic [7:0]  overrun_cnt;

   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;
   int t0, t1, t2, t3, t_en;

   sci_period_sched #(
      .CLK_FREQ_HZ (1000),
      .TICK_HZ     (100),
      .WDOG_TICKS  (16'd4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable_i    (enable_i),
      .interval_i  (interval_i),
      .trig_req    (trig_req),
      .trig_ack    (trig_ack),
      .trig_done   (trig_done),
      .busy        (busy),
      .tick        (tick),
      .seq_cnt     (seq_cnt),
      .overrun_cnt (overrun_cnt),
      .wdog_err    (wdog_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_req(output int at);
      int n = 0;
      while (trig_req !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("req_timeout", 32'(trig_req), 32'd1);
      at = cyc;
   endtask

   task automatic ack_pulse();
      trig_ack = 1'b1;
      step(1);
      trig_ack = 1'b0;
   endtask

   task automatic done_pulse();
      trig_done = 1'b1;
      step(1);
      trig_done = 1'b0;
   endtask

   // Ack in the first REQ cycle, done two cycles after the ack.
   task automatic txn();
      ack_pulse();
      step(1);
      done_pulse();
   endtask

   task automatic start(input logic [15:0] ivl);
      interval_i = ivl;
      enable_i   = 1'b1;
      t_en       = cyc;
   endtask

   task automatic stop();
      enable_i = 1'b0;
      step(4);
   endtask

   initial begin
      // Reset state
      step(2);
      check("rst_req", 32'(trig_req), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_seq", 32'(seq_cnt), 32'd0);
      check("rst_ovr", 32'(overrun_cnt), 32'd0);
      check("rst_wdog", 32'(wdog_err), 32'd0);
      rst_n = 1'b1;
      step(2);

      // Interval 3: immediate first request, then one every 30 cycles
      start(16'd3);
      wait_req(t0);
      check("s1_first_latency", 32'(t0 - t_en), 32'd2);
      txn();
      check("s1_seq1", 32'(seq_cnt), 32'd1);
      check("s1_idle_after_done", 32'(busy), 32'd0);
      ack_pulse();
      check("s1_stray_ack", 32'(seq_cnt), 32'd1);
      for (int i = 0; i < 40 && cyc != t0 + 9; i++) step(1);
      check("s1_tick_hi", 32'(tick), 32'd1);
      step(1);
      check("s1_tick_lo", 32'(tick), 32'd0);
      wait_req(t1);
      check("s1_period2", 32'(t1 - t0), 32'd30);
      txn();
      check("s1_seq2", 32'(seq_cnt), 32'd2);
      wait_req(t2);
      check("s1_period3", 32'(t2 - t1), 32'd30);
      txn();
      check("s1_seq3", 32'(seq_cnt), 32'd3);
      check("s1_ovr", 32'(overrun_cnt), 32'd0);
      stop();
      check("s1_off_req", 32'(trig_req), 32'd0);

      // Interval 0 behaves as 1; same-cycle ack+done goes straight back to WAIT
      start(16'd0);
      wait_req(t0);
      check("s2_seq_clear", 32'(seq_cnt), 32'd0);
      trig_ack  = 1'b1;
      trig_done = 1'b1;
      step(1);
      trig_ack  = 1'b0;
      trig_done = 1'b0;
      check("s2_ackdone_busy", 32'(busy), 32'd0);
      check("s2_ackdone_seq", 32'(seq_cnt), 32'd1);
      wait_req(t1);
      check("s2_period", 32'(t1 - t0), 32'd10);
`ifndef SCHED_WATCHDOG_EN
      ack_pulse();
      step(2700);
      check("s2_ovr_sat", 32'(overrun_cnt), 32'hFF);
      done_pulse();
      check("s2_sat_done_busy", 32'(busy), 32'd0);
`endif
      stop();

`ifndef SCHED_WATCHDOG_EN
      // Done held off for 70 cycles: two dropped triggers, next req on the following expiry
      start(16'd3);
      wait_req(t0);
      ack_pulse();
      step(68);
      check("s3_ovr", 32'(overrun_cnt), 32'd2);
      check("s3_no_req", 32'(trig_req), 32'd0);
      check("s3_busy", 32'(busy), 32'd1);
      done_pulse();
      check("s3_done_busy", 32'(busy), 32'd0);
      wait_req(t1);
      check("s3_next_req", 32'(t1 - t0), 32'd90);

      // Disable while trig_req is high and no ack arrives
      enable_i = 1'b0;
      step(1);
      check("s4_req_hold", 32'(trig_req), 32'd1);
      step(1);
      check("s4_req_drop", 32'(trig_req), 32'd0);
      check("s4_busy", 32'(busy), 32'd0);
      check("s4_seq", 32'(seq_cnt), 32'd1);
      step(3);
`endif

      // Disable in BUSY: finish the transaction, then stay idle
      start(16'd3);
      wait_req(t0);
      ack_pulse();
      enable_i = 1'b0;
      step(25);
      check("s5_busy_hold", 32'(busy), 32'd1);
      check("s5_no_req", 32'(trig_req), 32'd0);
      check("s5_tick_off", 32'(tick), 32'd0);
      done_pulse();
      check("s5_idle", 32'(busy), 32'd0);
      step(40);
      check("s5_stay_idle", 32'(trig_req), 32'd0);
      check("s5_seq_hold", 32'(seq_cnt), 32'd1);

      // Interval 3 -> 5 mid-period takes effect at the next boundary
      start(16'd3);
      wait_req(t0);
      txn();
      interval_i = 16'd5;
      wait_req(t1);
      check("s6_cur_period", 32'(t1 - t0), 32'd30);
      txn();
      wait_req(t2);
      check("s6_new_period", 32'(t2 - t1), 32'd50);
      txn();
      wait_req(t3);
      check("s6_new_period2", 32'(t3 - t2), 32'd50);
      txn();
      stop();

      // Watchdog: no done after ack
      start(16'd3);
      wait_req(t0);
      ack_pulse();
      step(38);
      check("s7_wdog_pre", 32'(wdog_err), 32'd0);
      check("s7_busy_pre", 32'(busy), 32'd1);
      step(1);
      check("s7_wdog", 32'(wdog_err), 32'(EXP_WD_ERR));
      check("s7_busy", 32'(busy), 32'(EXP_WD_BUSY));
      check("s7_ovr", 32'(overrun_cnt), 32'd1);
      done_pulse();
      wait_req(t1);
      check("s7_next_req", 32'(t1 - t0), 32'd60);

      // Re-enable clears the counters and the watchdog flag
      stop();
      start(16'd3);
      step(2);
      check("s8_seq_clr", 32'(seq_cnt), 32'd0);
      check("s8_ovr_clr", 32'(overrun_cnt), 32'd0);
      check("s8_wdog_clr", 32'(wdog_err), 32'd0);
      check("s8_req", 32'(trig_req), 32'd1);

      // Asynchronous reset mid-transaction drops trig_req at once
      rst_n = 1'b0;
      #1;
      check("rst_async_req", 32'(trig_req), 32'd0);
      check("rst_async_busy", 32'(busy), 32'd0);
      step(1);
      rst_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
